// File: rtl/audio_pkg.sv
// Shared types and constants for the tone mixer.
// Widths, envelope state encoding and saturation limits.
package audio_pkg;

    localparam int SAMPLE_W_DEF   = 32;
    localparam int PHASE_W_DEF    = 24;
    localparam int AMP_W_DEF      = 16;
    localparam int GAIN_SHIFT_DEF = 8;

    localparam logic [SAMPLE_W_DEF-1:0] SAMPLE_MAX = 32'h7FFF_FFFF;
    localparam logic [SAMPLE_W_DEF-1:0] SAMPLE_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_SUSTAIN,
        ST_RELEASE
    } env_state_e;

endpackage

// File: rtl/tone_envelope.sv
// Envelope FSM, sustain counter and phase accumulator.
// Produces the signed square/triangle tone for the current sample.
module tone_envelope
    import audio_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int AMP_W   = AMP_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_i,
    input  logic               start_i,
    input  logic [PHASE_W-1:0] inc_i,
    input  logic [AMP_W-1:0]   amp_i,
    input  logic [AMP_W-1:0]   step_i,
    input  logic [15:0]        dur_i,
    input  logic               tri_i,
    output env_state_e         state_o,
    output logic signed [AMP_W:0] tone_o
);

    typedef logic signed [AMP_W:0] tone_t;

    env_state_e         state_q, state_d;
    logic [AMP_W-1:0]   env_q, env_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [PHASE_W-1:0] inc_q;
    logic [AMP_W-1:0]   amp_q, step_q;
    logic [15:0]        dur_q;
    logic               tri_q;

    logic [AMP_W:0]     att_sum;
    logic [AMP_W-1:0]   tri_t;
    logic [2*AMP_W-1:0] prod;
    tone_t              tri_v, sq_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            env_q   <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            inc_q   <= '0;
            amp_q   <= '0;
            step_q  <= '0;
            dur_q   <= '0;
            tri_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            if (start_i) begin
                inc_q  <= inc_i;
                amp_q  <= amp_i;
                // A zero step would stall the envelope forever
                step_q <= (step_i == '0) ? AMP_W'(1) : step_i;
                dur_q  <= dur_i;
                tri_q  <= tri_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        att_sum = {1'b0, env_q} + {1'b0, step_q};
        if (start_i) begin
            state_d = ST_ATTACK;
            env_d   = '0;
            phase_d = '0;
            cnt_d   = '0;
        end else if (tick_i && state_q != ST_IDLE) begin
            phase_d = phase_q + inc_q;
            unique case (state_q)
                ST_ATTACK: begin
                    if (att_sum >= {1'b0, amp_q}) begin
                        env_d   = amp_q;
                        cnt_d   = '0;
                        state_d = (dur_q == '0) ? ST_RELEASE : ST_SUSTAIN;
                    end else begin
                        env_d = att_sum[AMP_W-1:0];
                    end
                end
                ST_SUSTAIN: begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_d == dur_q) begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (env_q <= step_q) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = env_q - step_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tri_t = phase_q[PHASE_W-2 -: AMP_W];
        if (phase_q[PHASE_W-1]) begin
            tri_t = ~tri_t;
        end
        prod  = {{AMP_W{1'b0}}, tri_t} * {{AMP_W{1'b0}}, env_q};
        // True result lies in [-env, +env], so truncation is exact
        tri_v = tone_t'((prod >> (AMP_W-1)) - {{AMP_W{1'b0}}, env_q});
        sq_v  = $signed({1'b0, env_q});
        if (phase_q[PHASE_W-1]) begin
            sq_v = -sq_v;
        end
        if (state_q == ST_IDLE) begin
            tone_o = '0;
        end else if (tri_q) begin
            tone_o = tri_v;
        end else begin
            tone_o = sq_v;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/tone_mixer_gen.sv
// Note-driven tone generator mixed into the audio controller stream.
// Handles the read/write handshake, gain, saturation and output regs.
module tone_mixer_gen
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int PHASE_W    = PHASE_W_DEF,
    parameter int AMP_W      = AMP_W_DEF,
    parameter int GAIN_SHIFT = GAIN_SHIFT_DEF
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                note_valid,
    output logic                note_ready,
    input  logic [PHASE_W-1:0]  note_inc,
    input  logic [AMP_W-1:0]    note_amp,
    input  logic [AMP_W-1:0]    note_step,
    input  logic [15:0]         note_dur,
    input  logic                note_tri,
    input  logic                audio_in_available,
    input  logic                audio_out_allowed,
    input  logic [SAMPLE_W-1:0] left_channel_audio_in,
    input  logic [SAMPLE_W-1:0] right_channel_audio_in,
    output logic                read_audio_in,
    output logic [SAMPLE_W-1:0] left_channel_audio_out,
    output logic [SAMPLE_W-1:0] right_channel_audio_out,
    output logic                write_audio_out,
    output logic                busy
);

    localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    env_state_e                state;
    logic signed [AMP_W:0]     tone;
    logic                      accept;
    logic                      wp_q;
    logic [SAMPLE_W-1:0]       l_q, l_d, r_q, r_d;
    logic [SAMPLE_W-1:0]       tone_ext, scaled;

    function automatic logic [SAMPLE_W-1:0] mix_sat(
        input logic [SAMPLE_W-1:0] a,
        input logic [SAMPLE_W-1:0] b
    );
        logic [SAMPLE_W:0] s;
        s = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
        if (s[SAMPLE_W] != s[SAMPLE_W-1]) begin
            return s[SAMPLE_W] ? SAT_MIN : SAT_MAX;
        end
        return s[SAMPLE_W-1:0];
    endfunction

    assign note_ready    = (state == ST_IDLE);
    assign busy          = ~note_ready;
    assign accept        = note_valid & note_ready;
    // One write per read: a pending write blocks the next pop
    assign read_audio_in = audio_in_available & audio_out_allowed & ~wp_q;

    tone_envelope #(
        .PHASE_W (PHASE_W),
        .AMP_W   (AMP_W)
    ) u_env (
        .clk     (CLOCK_50),
        .reset   (reset),
        .tick_i  (read_audio_in),
        .start_i (accept),
        .inc_i   (note_inc),
        .amp_i   (note_amp),
        .step_i  (note_step),
        .dur_i   (note_dur),
        .tri_i   (note_tri),
        .state_o (state),
        .tone_o  (tone)
    );

    assign tone_ext = {{(SAMPLE_W-AMP_W-1){tone[AMP_W]}}, tone};
    assign scaled   = tone_ext << GAIN_SHIFT;

    always_comb begin
        l_d = l_q;
        r_d = r_q;
        if (read_audio_in) begin
            l_d = mix_sat(left_channel_audio_in, scaled);
            r_d = mix_sat(right_channel_audio_in, scaled);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wp_q <= 1'b0;
            l_q  <= '0;
            r_q  <= '0;
        end else begin
            wp_q <= read_audio_in;
            l_q  <= l_d;
            r_q  <= r_d;
        end
    end

    assign write_audio_out         = wp_q;
    assign left_channel_audio_out  = l_q;
    assign right_channel_audio_out = r_q;

endmodule

// File: tb/tb_tone_mixer_gen.sv
// Directed bench for tone_mixer_gen with hand-computed samples.
module tb_tone_mixer_gen;
    import audio_pkg::*;

    logic        clk;
    logic        reset;
    logic        note_valid;
    logic        note_ready;
    logic [23:0] note_inc;
    logic [15:0] note_amp;
    logic [15:0] note_step;
    logic [15:0] note_dur;
    logic        note_tri;
    logic        avail;
    logic        allowed;
    logic [31:0] lin, rin;
    logic        rd;
    logic [31:0] lout, rout;
    logic        wr;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    tone_mixer_gen dut (
        .CLOCK_50                (clk),
        .reset                   (reset),
        .note_valid              (note_valid),
        .note_ready              (note_ready),
        .note_inc                (note_inc),
        .note_amp                (note_amp),
        .note_step               (note_step),
        .note_dur                (note_dur),
        .note_tri                (note_tri),
        .audio_in_available      (avail),
        .audio_out_allowed       (allowed),
        .left_channel_audio_in   (lin),
        .right_channel_audio_in  (rin),
        .read_audio_in           (rd),
        .left_channel_audio_out  (lout),
        .right_channel_audio_out (rout),
        .write_audio_out         (wr),
        .busy                    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input string tag, input logic [31:0] l,
                          input logic [31:0] r, input logic [31:0] el,
                          input logic [31:0] er);
        avail = 1'b1;
        allowed = 1'b1;
        lin = l;
        rin = r;
        #3 chk({tag, ":rd"}, {31'd0, rd}, 32'd1);
        cyc();
        avail = 1'b0;
        #3;
        chk({tag, ":wr"}, {31'd0, wr}, 32'd1);
        chk({tag, ":L"}, lout, el);
        chk({tag, ":R"}, rout, er);
        cyc();
    endtask

    task automatic sample_t(input string tag, input int l, input int r,
                            input int tone);
        sample(tag, l, r, l + tone * 256, r + tone * 256);
    endtask

    task automatic note(input logic [23:0] inc, input logic [15:0] amp,
                        input logic [15:0] step, input logic [15:0] dur,
                        input logic tri_);
        note_inc = inc;
        note_amp = amp;
        note_step = step;
        note_dur = dur;
        note_tri = tri_;
        note_valid = 1'b1;
        #3 chk("note_ready", {31'd0, note_ready}, 32'd1);
        cyc();
        note_valid = 1'b0;
        chk("note_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 64; i++) begin
            if (!busy) break;
            avail = 1'b1;
            allowed = 1'b1;
            lin = '0;
            rin = '0;
            cyc();
            avail = 1'b0;
            cyc();
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int sq_tone[8];
        sq_tone = '{0, 50, 100, 100, 100, 100, 50, 0};
        reset = 1'b1;
        note_valid = 1'b0;
        note_inc = '0;
        note_amp = '0;
        note_step = '0;
        note_dur = '0;
        note_tri = 1'b0;
        avail = 1'b0;
        allowed = 1'b0;
        lin = '0;
        rin = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, note_ready}, 32'd1);
        chk("rst_wr", {31'd0, wr}, 32'd0);
        chk("rst_L", lout, 32'd0);
        chk("rst_R", rout, 32'd0);
        cyc();

        sample_t("pass", 1234, -5, 0);

        note(24'h100000, 16'd100, 16'd50, 16'd3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            sample_t($sformatf("sq%0d", i), 0, 0, sq_tone[i]);
            if (i == 2) begin
                note_amp = 16'd7;
                note_valid = 1'b1;
                #3 chk("busy_rej", {31'd0, note_ready}, 32'd0);
                cyc();
                note_valid = 1'b0;
            end
            if (i == 5) chk("sq_busy6", {31'd0, busy}, 32'd1);
            if (i == 6) chk("sq_idle7", {31'd0, busy}, 32'd0);
        end

        note(24'h800000, 16'd100, 16'd100, 16'd1, 1'b0);
        sample_t("flip0", 1000, -1000, 0);
        sample_t("flip1", 1000, -1000, -100);
        sample_t("flip2", 1000, -1000, 100);
        sample_t("flip3", 1000, -1000, 0);

        note(24'h000000, 16'd100, 16'd100, 16'd1, 1'b0);
        sample("satp0", 32'h7FFFFF00, 0, 32'h7FFFFF00, 0);
        sample("satp1", 32'h7FFFFF00, 0, SAMPLE_MAX, 32'd25600);
        sample("satp2", 32'h7FFF9BFF, 5, SAMPLE_MAX, 32'd25605);
        drain("satp_drain");
        note(24'h800000, 16'd100, 16'd100, 16'd1, 1'b0);
        sample_t("satn0", 0, 0, 0);
        sample("satn1", 32'h80000010, 32'h80006400, SAMPLE_MIN, SAMPLE_MIN);
        sample_t("satn2", 0, 0, 100);
        drain("satn_drain");

        note(24'h400000, 16'd100, 16'd100, 16'd10, 1'b1);
        sample_t("tri0", 0, 0, 0);
        sample_t("tri1", 0, 0, 0);
        sample_t("tri2", 0, 0, 99);
        sample_t("tri3", 0, 0, -1);
        sample_t("tri4", 0, 0, -100);
        drain("tri_drain");

        avail = 1'b1;
        allowed = 1'b1;
        lin = '0;
        rin = '0;
        for (int i = 0; i < 10; i++) begin
            #3;
            chk($sformatf("hs_rd%0d", i), {31'd0, rd}, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("hs_wr%0d", i), {31'd0, wr}, (i % 2 == 1) ? 1 : 0);
            cyc();
        end
        allowed = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #3;
            chk($sformatf("blk_rd%0d", i), {31'd0, rd}, 32'd0);
            chk($sformatf("blk_wr%0d", i), {31'd0, wr}, 32'd0);
            cyc();
        end
        avail = 1'b0;
        allowed = 1'b1;

        note(24'h000000, 16'd100, 16'd50, 16'd0, 1'b0);
        sample_t("d0_0", 0, 0, 0);
        sample_t("d0_1", 0, 0, 50);
        sample_t("d0_2", 0, 0, 100);
        sample_t("d0_3", 0, 0, 50);
        chk("d0_idle", {31'd0, busy}, 32'd0);
        sample_t("d0_4", 0, 0, 0);

        note(24'h100000, 16'd0, 16'd5, 16'd0, 1'b0);
        sample_t("a0_0", 77, 77, 0);
        chk("a0_busy", {31'd0, busy}, 32'd1);
        sample_t("a0_1", 77, 77, 0);
        chk("a0_idle", {31'd0, busy}, 32'd0);

        note(24'h000000, 16'd2, 16'd0, 16'd0, 1'b0);
        sample_t("s0_0", 0, 0, 0);
        sample_t("s0_1", 0, 0, 1);
        sample_t("s0_2", 0, 0, 2);
        sample_t("s0_3", 0, 0, 1);
        chk("s0_idle", {31'd0, busy}, 32'd0);

        note_inc = '0;
        note_amp = 16'd100;
        note_step = 16'd50;
        note_dur = 16'd0;
        note_tri = 1'b0;
        note_valid = 1'b1;
        sample_t("acc0", 9, 9, 0);
        note_valid = 1'b0;
        chk("acc_busy", {31'd0, busy}, 32'd1);
        sample_t("acc1", 9, 9, 0);
        sample_t("acc2", 9, 9, 50);
        drain("acc_drain");

        note(24'h000000, 16'd100, 16'd100, 16'd20, 1'b0);
        sample_t("rs0", 0, 0, 0);
        sample_t("rs1", 0, 0, 100);
        avail = 1'b1;
        allowed = 1'b1;
        lin = 32'd3;
        rin = 32'd3;
        cyc();
        avail = 1'b0;
        reset = 1'b1;
        #3 chk("rs_pend", {31'd0, wr}, 32'd1);
        cyc();
        reset = 1'b0;
        #3;
        chk("rs_wr", {31'd0, wr}, 32'd0);
        chk("rs_busy", {31'd0, busy}, 32'd0);
        chk("rs_L", lout, 32'd0);
        chk("rs_R", rout, 32'd0);
        cyc();
        sample_t("rs_pass", 42, -42, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_mixer_gen.md
# tone_mixer_gen

Note-driven tone synthesiser and mixer that sits directly upstream of `Audio_Controller`. It consumes captured line/mic samples on the controller's read side, adds an enveloped square or triangle tone with saturation, and writes the mixed stereo sample back on the controller's write side. Notes arrive one at a time over a valid/ready handshake from game logic.

## Interface
- `SAMPLE_W`, default 32: controller sample width.
- `PHASE_W`, default 24: phase accumulator width.
- `AMP_W`, default 16: envelope/amplitude width, unsigned.
- `GAIN_SHIFT`, default 8: left shift applied to the tone before mixing.
- `CLOCK_50` input 1: sole clock.
- `reset` input 1: synchronous, active-high.
- `note_valid` input 1: note request.
- `note_ready` output 1: high in IDLE; accept = valid & ready.
- `note_inc` input PHASE_W: phase increment per sample.
- `note_amp` input AMP_W: peak level, max 2^(AMP_W-1)-1.
- `note_step` input AMP_W: attack/release step per sample, 0 treated as 1.
- `note_dur` input 16: sustain length in samples.
- `note_tri` input 1: 0 square, 1 triangle.
- `audio_in_available` input 1: controller has an input sample.
- `audio_out_allowed` input 1: controller output FIFO has space.
- `left_channel_audio_in`, `right_channel_audio_in` input SAMPLE_W: signed input samples.
- `read_audio_in` output 1: pops the input sample.
- `left_channel_audio_out`, `right_channel_audio_out` output SAMPLE_W: mixed samples, registered.
- `write_audio_out` output 1: pushes the mixed sample.
- `busy` output 1: state ≠ IDLE.

## Operation
- **States.** IDLE → ATTACK → SUSTAIN → RELEASE → IDLE.
- **Note accept.** A note is accepted only in IDLE. On accept:
  - latch the parameters;
  - phase ← 0, env ← 0;
  - go to ATTACK.
- **Requests while busy.** `note_valid` while busy is ignored; the requester holds it.
- **Per-sample step.** The envelope, phase and state advance only on a sample tick, i.e. a cycle where `read_audio_in`=1.
- **ATTACK.** env ← min(env+step, amp). When env reaches amp, go to SUSTAIN, or directly to RELEASE if dur=0. amp=0 leaves ATTACK on the first tick.
- **SUSTAIN.** A counter counts dur ticks, then goes to RELEASE.
- **RELEASE.** env ← max(env−step, 0). At 0, go to IDLE.
- **Phase.** phase ← phase+inc on every tick (modulo 2^PHASE_W) while not IDLE.
- **Square tone.** phase MSB=0 → +env, else −env.
- **Triangle tone.**
  - t = phase[PHASE_W-2 -: AMP_W], inverted bitwise when phase MSB=1.
  - tone = ((t·env) >> (AMP_W−1)) − env, signed AMP_W+1 bits.
- **IDLE tone.** tone = 0.
- **Mix.**
  - scaled = sign_extend(tone) << GAIN_SHIFT, SAMPLE_W bits.
  - out = in + scaled, computed at SAMPLE_W+1 bits.
  - Saturate to 0x7FFFFFFF / 0x80000000.
  - The same tone is added to both channels.
- **Reset.** Reset mid-note aborts the note and discards any pending write.

## Timing
- **Read strobe.** `read_audio_in` = `audio_in_available` & `audio_out_allowed` & !`write_pending`. It is combinational; the controller pops in the same cycle.
- **Write latency.** Tick in cycle N: the mixed samples are registered at the end of N. `write_audio_out`=1 for exactly cycle N+1, and the data is stable from N+1 until the next write.
- **No back-to-back reads.** A read in N+1 is blocked by `write_pending`. Maximum throughput is one sample per 2 cycles, which is far above the 48 kHz sample rate.
- **Write is unconditional.** The write in N+1 is issued whether or not `audio_out_allowed` still holds. Space was guaranteed in N and the block issues only one write per read.
- **Tone timing.** The tone used for the sample in cycle N comes from the envelope/phase before the update in N.
- **Note accept timing.** A note accepted in cycle M affects only ticks after M. A tick in M still uses the old (zero) tone.
- **Reset values.**
  - state IDLE, env 0, phase 0, counter 0;
  - `write_audio_out` 0;
  - both audio outputs 0;
  - `busy` 0;
  - `note_ready` 1 from the first cycle after reset.

## Structure
- Shared package `audio_pkg`:
  - state enum (IDLE/ATTACK/SUSTAIN/RELEASE);
  - the `SAMPLE_MAX`/`SAMPLE_MIN` saturation constants;
  - default widths.
- Sub-module `tone_envelope`: FSM, envelope, sustain counter and phase accumulator, producing the signed tone.
- Top level: handshake, mix, saturation and output registers.

## Test plan
1. **Idle passthrough.** Reset, no note, input L=1234, R=−5 → one read, then the next cycle a write with L=1234, R=−5. `note_ready`=1.
2. **Square note.**
   - Note: inc=0x100000, amp=100, step=50, dur=3, square; input 0.
   - Envelope on successive ticks: 0, 50, 100 (ATTACK), three SUSTAIN ticks, then 50, 0 (RELEASE) → IDLE.
   - Outputs are ±env<<8, sign flipping every 8 ticks.
3. **Saturation.** Input L=0x7FFFFF00 plus +100<<8 → 0x7FFFFFFF. Input 0x80000010 plus −100<<8 → 0x80000000.
4. **Handshake.**
   - Hold `audio_in_available`=1, `audio_out_allowed`=1 continuously → reads/writes alternate, never two reads in consecutive cycles.
   - `audio_out_allowed`=0 → no read.
5. **Busy / edge-case notes.**
   - A second `note_valid` during SUSTAIN is not accepted.
   - dur=0 goes ATTACK→RELEASE.
   - amp=0 returns to IDLE after 2 ticks with all-zero tone.
6. **Reset mid-note.** Assert `reset` during SUSTAIN with a write pending → next cycle `write_audio_out`=0, IDLE, env 0, outputs 0.
